// File: rtl/can_pkg.sv
// Shared types, field lengths and helpers for the standard-format CAN receive sequencer.
package can_pkg;

    typedef enum logic [3:0] {
        S_WAIT_IDLE = 4'd0,
        S_IDLE      = 4'd1,
        S_ID        = 4'd2,
        S_RTR       = 4'd3,
        S_IDE       = 4'd4,
        S_R0        = 4'd5,
        S_DLC       = 4'd6,
        S_DATA      = 4'd7,
        S_CRC       = 4'd8,
        S_CRC_DEL   = 4'd9,
        S_ACK       = 4'd10,
        S_ACK_DEL   = 4'd11,
        S_EOF       = 4'd12,
        S_IFS       = 4'd13
    } can_state_e;

    localparam logic [6:0]  CAN_ID_LEN     = 7'd11;
    localparam logic [6:0]  CAN_DLC_LEN    = 7'd4;
    localparam logic [6:0]  CAN_CRC_LEN    = 7'd15;
    localparam logic [6:0]  CAN_EOF_LEN    = 7'd7;
    localparam logic [6:0]  CAN_IFS_LEN    = 7'd3;
    localparam logic [6:0]  CAN_IDLE_BITS  = 7'd11;
    localparam logic [3:0]  CAN_MAX_BYTES  = 4'd8;
    localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;

    function automatic logic [14:0] crc15Next(input logic [14:0] crc, input logic bitIn);
        logic [14:0] shifted;
        shifted = {crc[13:0], 1'b0};
        return (bitIn ^ crc[14]) ? (shifted ^ CAN_CRC15_POLY) : shifted;
    endfunction

    // Remote frames carry no data regardless of DLC; DLC above 8 still means 8 bytes.
    function automatic logic [6:0] dataBitCount(input logic rtr, input logic [3:0] dlc);
        logic [3:0] bytes;
        bytes = (dlc > CAN_MAX_BYTES) ? CAN_MAX_BYTES : dlc;
        return rtr ? 7'd0 : {bytes, 3'b000};
    endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 accumulator, one bit per enabled sample point.
module can_crc15
    import can_pkg::*;
(
    input  logic        SP,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [14:0] crc
);

    logic [14:0] crc_q;

    // Clearing and feeding on the same edge lets the SOF bit start a fresh CRC.
    always_ff @(posedge SP) begin
        if (reset) begin
            crc_q <= '0;
        end else if (clear) begin
            crc_q <= enable ? crc15Next(15'd0, bit_in) : 15'd0;
        end else if (enable) begin
            crc_q <= crc15Next(crc_q, bit_in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/can_frame_sequencer.sv
// Bit-level receive sequencer for standard CAN frames: destuffing, field capture and CRC-15 check.
module can_frame_sequencer
    import can_pkg::*;
(
    input  logic        SP,
    input  logic        reset,
    input  logic        RX,
    output logic        EOF_Flag,
    output logic        Frame_Valid,
    output logic        Stuff_Error,
    output logic        Form_Error,
    output logic        CRC_Error,
    output logic [10:0] ID,
    output logic        RTR,
    output logic [3:0]  DLC,
    output logic [63:0] Data,
    output logic [3:0]  State
);

    can_state_e  state_q;
    logic [6:0]  bitCnt_q;
    logic [2:0]  runCnt_q;
    logic        lastBit_q;
    logic [6:0]  nBits_q;
    logic [14:0] crcRx_q;
    logic [10:0] id_q;
    logic        rtr_q;
    logic [3:0]  dlc_q;
    logic [63:0] data_q;
    logic        frameValid_q, stuffErr_q, formErr_q, crcErr_q, eofFlag_q;

    logic        stuffZone, stuffBit, stuffErr, sof, crcEnable, crcMismatch;
    logic [14:0] crcCalc;
    logic [5:0]  dataIdx;
    logic [3:0]  dlcNext;
    logic [6:0]  nBitsNext;

    // Destuffing covers SOF through the last CRC bit; no stuff bit is expected after the final CRC bit.
    always_comb begin
        stuffZone   = state_q inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC};
        stuffBit    = stuffZone && (runCnt_q == 3'd5);
        stuffErr    = stuffBit && (RX == lastBit_q);
        sof         = ((state_q == S_IDLE) || (state_q == S_IFS)) && !RX;
        crcEnable   = sof || (!stuffBit && (state_q inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA}));
        crcMismatch = (crcRx_q != crcCalc);
        dataIdx     = 6'd63 - bitCnt_q[5:0];
        dlcNext     = {dlc_q[2:0], RX};
        nBitsNext   = dataBitCount(rtr_q, dlcNext);
    end

    can_crc15 u_crc (
        .SP     (SP),
        .reset  (reset),
        .clear  (sof),
        .enable (crcEnable),
        .bit_in (RX),
        .crc    (crcCalc)
    );

    always_ff @(posedge SP) begin
        if (reset) begin
            state_q      <= S_WAIT_IDLE;
            bitCnt_q     <= '0;
            runCnt_q     <= '0;
            lastBit_q    <= 1'b0;
            nBits_q      <= '0;
            crcRx_q      <= '0;
            id_q         <= '0;
            rtr_q        <= 1'b0;
            dlc_q        <= '0;
            data_q       <= '0;
            frameValid_q <= 1'b0;
            stuffErr_q   <= 1'b0;
            formErr_q    <= 1'b0;
            crcErr_q     <= 1'b0;
            eofFlag_q    <= 1'b0;
        end else begin
            frameValid_q <= 1'b0;
            stuffErr_q   <= 1'b0;
            formErr_q    <= 1'b0;
            crcErr_q     <= 1'b0;
            eofFlag_q    <= 1'b0;

            if (stuffZone) begin
                if (stuffBit || (RX != lastBit_q)) begin
                    runCnt_q  <= 3'd1;
                    lastBit_q <= RX;
                end else begin
                    runCnt_q <= runCnt_q + 3'd1;
                end
            end

            case (state_q)
                S_WAIT_IDLE: begin
                    if (!RX) begin
                        bitCnt_q <= '0;
                    end else if (bitCnt_q == CAN_IDLE_BITS - 7'd1) begin
                        state_q  <= S_IDLE;
                        bitCnt_q <= '0;
                    end else begin
                        bitCnt_q <= bitCnt_q + 7'd1;
                    end
                end
                S_IDLE, S_IFS: begin
                    if (sof) begin
                        id_q      <= '0;
                        rtr_q     <= 1'b0;
                        dlc_q     <= '0;
                        data_q    <= '0;
                        crcRx_q   <= '0;
                        runCnt_q  <= 3'd1;
                        lastBit_q <= 1'b0;
                        bitCnt_q  <= '0;
                        state_q   <= S_ID;
                    end else if (state_q == S_IFS) begin
                        if (bitCnt_q == CAN_IFS_LEN - 7'd1) begin
                            state_q  <= S_IDLE;
                            bitCnt_q <= '0;
                        end else begin
                            bitCnt_q <= bitCnt_q + 7'd1;
                        end
                    end
                end
                S_CRC_DEL: begin
                    formErr_q <= !RX;
                    crcErr_q  <= crcMismatch;
                    bitCnt_q  <= '0;
                    state_q   <= (!RX || crcMismatch) ? S_WAIT_IDLE : S_ACK;
                end
                S_ACK: begin
                    state_q <= S_ACK_DEL;
                end
                S_ACK_DEL: begin
                    bitCnt_q <= '0;
                    if (RX) begin
                        frameValid_q <= 1'b1;
                        state_q      <= S_EOF;
                    end else begin
                        formErr_q <= 1'b1;
                        state_q   <= S_WAIT_IDLE;
                    end
                end
                S_EOF: begin
                    eofFlag_q <= 1'b1;
                    if (bitCnt_q == CAN_EOF_LEN - 7'd1) begin
                        state_q  <= S_IFS;
                        bitCnt_q <= '0;
                    end else begin
                        bitCnt_q <= bitCnt_q + 7'd1;
                    end
                end
                default: begin
                    if (stuffBit) begin
                        if (stuffErr) begin
                            stuffErr_q <= 1'b1;
                            state_q    <= S_WAIT_IDLE;
                            bitCnt_q   <= '0;
                        end
                    end else begin
                        case (state_q)
                            S_ID: begin
                                id_q <= {id_q[9:0], RX};
                                if (bitCnt_q == CAN_ID_LEN - 7'd1) begin
                                    state_q  <= S_RTR;
                                    bitCnt_q <= '0;
                                end else begin
                                    bitCnt_q <= bitCnt_q + 7'd1;
                                end
                            end
                            S_RTR: begin
                                rtr_q   <= RX;
                                state_q <= S_IDE;
                            end
                            S_IDE: begin
                                if (RX) begin
                                    formErr_q <= 1'b1;
                                    state_q   <= S_WAIT_IDLE;
                                end else begin
                                    state_q <= S_R0;
                                end
                            end
                            S_R0: begin
                                state_q <= S_DLC;
                            end
                            S_DLC: begin
                                dlc_q <= dlcNext;
                                if (bitCnt_q == CAN_DLC_LEN - 7'd1) begin
                                    nBits_q  <= nBitsNext;
                                    bitCnt_q <= '0;
                                    state_q  <= (nBitsNext == 7'd0) ? S_CRC : S_DATA;
                                end else begin
                                    bitCnt_q <= bitCnt_q + 7'd1;
                                end
                            end
                            S_DATA: begin
                                data_q[dataIdx] <= RX;
                                if (bitCnt_q == nBits_q - 7'd1) begin
                                    state_q  <= S_CRC;
                                    bitCnt_q <= '0;
                                end else begin
                                    bitCnt_q <= bitCnt_q + 7'd1;
                                end
                            end
                            S_CRC: begin
                                crcRx_q <= {crcRx_q[13:0], RX};
                                if (bitCnt_q == CAN_CRC_LEN - 7'd1) begin
                                    state_q  <= S_CRC_DEL;
                                    bitCnt_q <= '0;
                                end else begin
                                    bitCnt_q <= bitCnt_q + 7'd1;
                                end
                            end
                            default: begin
                                state_q <= S_WAIT_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign EOF_Flag    = eofFlag_q;
    assign Frame_Valid = frameValid_q;
    assign Stuff_Error = stuffErr_q;
    assign Form_Error  = formErr_q;
    assign CRC_Error   = crcErr_q;
    assign ID          = id_q;
    assign RTR         = rtr_q;
    assign DLC         = dlc_q;
    assign Data        = data_q;
    assign State       = state_q;

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Self-checking bench for can_frame_sequencer: table of encoded frames plus reset/IFS sequences.
module tb_can_frame_sequencer;

    localparam logic [3:0] ST_WAIT_IDLE = 4'd0;
    localparam logic [3:0] ST_IDLE      = 4'd1;
    localparam logic [3:0] ST_DATA      = 4'd7;

    logic        SP = 1'b0;
    logic        reset;
    logic        RX;
    logic        EOF_Flag, Frame_Valid, Stuff_Error, Form_Error, CRC_Error, RTR;
    logic [10:0] ID;
    logic [3:0]  DLC;
    logic [63:0] Data;
    logic [3:0]  State;

    can_frame_sequencer dut (
        .SP          (SP),
        .reset       (reset),
        .RX          (RX),
        .EOF_Flag    (EOF_Flag),
        .Frame_Valid (Frame_Valid),
        .Stuff_Error (Stuff_Error),
        .Form_Error  (Form_Error),
        .CRC_Error   (CRC_Error),
        .ID          (ID),
        .RTR         (RTR),
        .DLC         (DLC),
        .Data        (Data),
        .State       (State)
    );

    always #5 SP = ~SP;

    typedef struct {
        logic [10:0] id;
        bit          rtr;
        bit          ide;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic [14:0] crcXor;
        bit          crcDel;
        bit          ackDel;
        bit          flipStuff;
        int          expFv;
        int          expStuff;
        int          expForm;
        int          expCrc;
        int          expEof;
        bit          checkFields;
        logic [10:0] expId;
        bit          expRtr;
        logic [3:0]  expDlc;
        logic [63:0] expData;
    } vec_t;

    vec_t vecs[11];
    bit   txQ[$];
    int   nStuff, firstStuff;
    int   nChecks = 0;
    int   nFail = 0;
    int   fvCnt, stuffCnt, formCnt, crcCnt, eofCnt;
    int   fvIdx, eofFirst, eofLast, bitIdx, stateAtErr;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Transmitter model: raw frame bits, CRC-15 over SOF..DATA, then bit stuffing through the CRC field.
    task automatic buildFrame(input logic [10:0] id, input bit rtr, input bit ide, input logic [3:0] dlc,
                              input logic [63:0] data, input logic [14:0] crcXor, input bit crcDel,
                              input bit ackDel, input bit flipStuff);
        bit          raw[$];
        logic [14:0] crc;
        int          n, run;
        bit          last;
        txQ.delete();
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(ide);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < 8 * n; i++) raw.push_back(data[63 - i]);
        crc = '0;
        foreach (raw[i]) begin
            if (raw[i] ^ crc[14]) crc = {crc[13:0], 1'b0} ^ 15'h4599;
            else                  crc = {crc[13:0], 1'b0};
        end
        crc = crc ^ crcXor;
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        run = 0;
        last = 1'b1;
        nStuff = 0;
        firstStuff = -1;
        foreach (raw[i]) begin
            if (run == 5) begin
                txQ.push_back(!last);
                if (firstStuff < 0) firstStuff = txQ.size() - 1;
                nStuff++;
                last = !last;
                run = 1;
            end
            if (raw[i] == last) run++;
            else begin
                run = 1;
                last = raw[i];
            end
            txQ.push_back(raw[i]);
        end
        txQ.push_back(crcDel);
        txQ.push_back(1'b0);
        txQ.push_back(ackDel);
        repeat (7) txQ.push_back(1'b1);
        if (flipStuff && firstStuff >= 0) txQ[firstStuff] = !txQ[firstStuff];
    endtask

    task automatic resetMonitor();
        fvCnt = 0; stuffCnt = 0; formCnt = 0; crcCnt = 0; eofCnt = 0;
        fvIdx = -1; eofFirst = -1; eofLast = -1; bitIdx = 0; stateAtErr = 15;
    endtask

    task automatic sendBit(input bit b);
        RX = b;
        @(posedge SP);
        #1;
        if (Frame_Valid) begin
            fvCnt++;
            fvIdx = bitIdx;
        end
        if (EOF_Flag) begin
            if (eofCnt == 0) eofFirst = bitIdx;
            eofLast = bitIdx;
            eofCnt++;
        end
        if (Stuff_Error) stuffCnt++;
        if (Form_Error)  formCnt++;
        if (CRC_Error)   crcCnt++;
        if (Stuff_Error || Form_Error || CRC_Error) stateAtErr = int'(State);
        bitIdx++;
    endtask

    task automatic applyStimulus(input vec_t v, input int k);
        int n;
        buildFrame(v.id, v.rtr, v.ide, v.dlc, v.data, v.crcXor, v.crcDel, v.ackDel, v.flipStuff);
        resetMonitor();
        foreach (txQ[i]) sendBit(txQ[i]);
        repeat (12) sendBit(1'b1);
        n = v.rtr ? 0 : ((v.dlc > 4'd8) ? 8 : int'(v.dlc));
        checkOutput($sformatf("v%0d_frame_valid", k), 64'(fvCnt), 64'(v.expFv));
        checkOutput($sformatf("v%0d_stuff_error", k), 64'(stuffCnt), 64'(v.expStuff));
        checkOutput($sformatf("v%0d_form_error", k), 64'(formCnt), 64'(v.expForm));
        checkOutput($sformatf("v%0d_crc_error", k), 64'(crcCnt), 64'(v.expCrc));
        checkOutput($sformatf("v%0d_eof_cycles", k), 64'(eofCnt), 64'(v.expEof));
        if (v.expFv != 0) begin
            checkOutput($sformatf("v%0d_fv_bit_index", k), 64'(fvIdx), 64'(36 + 8 * n + nStuff));
            checkOutput($sformatf("v%0d_eof_first", k), 64'(eofFirst), 64'(fvIdx + 1));
            checkOutput($sformatf("v%0d_eof_last", k), 64'(eofLast), 64'(fvIdx + 7));
        end
        if (v.checkFields) begin
            checkOutput($sformatf("v%0d_id", k), 64'(ID), 64'(v.expId));
            checkOutput($sformatf("v%0d_rtr", k), 64'(RTR), 64'(v.expRtr));
            checkOutput($sformatf("v%0d_dlc", k), 64'(DLC), 64'(v.expDlc));
            checkOutput($sformatf("v%0d_data", k), Data, v.expData);
        end
        if ((v.expStuff + v.expForm + v.expCrc) != 0)
            checkOutput($sformatf("v%0d_state_at_error", k), 64'(stateAtErr), 64'(ST_WAIT_IDLE));
        checkOutput($sformatf("v%0d_state_after", k), 64'(State), 64'(ST_IDLE));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //           id      rtr ide dlc  data                    crcXor  cDel aDel flip fv st fo cr eof chk expId  eRtr eDlc expData
        vecs[0]  = '{11'h123, 0, 0, 4'd1,  64'hA5FF_FFFF_FFFF_FFFF, 15'h0000, 1, 1, 0, 1, 0, 0, 0, 7, 1, 11'h123, 0, 4'd1,  64'hA500_0000_0000_0000};
        vecs[1]  = '{11'h000, 0, 0, 4'd0,  64'h0,                   15'h0000, 1, 1, 0, 1, 0, 0, 0, 7, 1, 11'h000, 0, 4'd0,  64'h0};
        vecs[2]  = '{11'h000, 0, 0, 4'd0,  64'h0,                   15'h0000, 1, 1, 1, 0, 1, 0, 0, 0, 0, 11'h000, 0, 4'd0,  64'h0};
        vecs[3]  = '{11'h123, 0, 0, 4'd1,  64'hA5FF_FFFF_FFFF_FFFF, 15'h0001, 1, 1, 0, 0, 0, 0, 1, 0, 0, 11'h000, 0, 4'd0,  64'h0};
        vecs[4]  = '{11'h123, 0, 0, 4'd1,  64'hA5FF_FFFF_FFFF_FFFF, 15'h0000, 0, 1, 0, 0, 0, 1, 0, 0, 0, 11'h000, 0, 4'd0,  64'h0};
        vecs[5]  = '{11'h123, 0, 1, 4'd1,  64'hA5FF_FFFF_FFFF_FFFF, 15'h0000, 1, 1, 0, 0, 0, 1, 0, 0, 0, 11'h000, 0, 4'd0,  64'h0};
        vecs[6]  = '{11'h123, 0, 0, 4'd1,  64'hA5FF_FFFF_FFFF_FFFF, 15'h0000, 1, 0, 0, 0, 0, 1, 0, 0, 0, 11'h000, 0, 4'd0,  64'h0};
        vecs[7]  = '{11'h2AA, 1, 0, 4'd4,  64'hDEAD_BEEF_0123_4567, 15'h0000, 1, 1, 0, 1, 0, 0, 0, 7, 1, 11'h2AA, 1, 4'd4,  64'h0};
        vecs[8]  = '{11'h555, 0, 0, 4'd15, 64'h0123_4567_89AB_CDEF, 15'h0000, 1, 1, 0, 1, 0, 0, 0, 7, 1, 11'h555, 0, 4'd15, 64'h0123_4567_89AB_CDEF};
        vecs[9]  = '{11'h7FF, 0, 0, 4'd2,  64'hFF00_1234_0000_0000, 15'h0000, 1, 1, 0, 1, 0, 0, 0, 7, 1, 11'h7FF, 0, 4'd2,  64'hFF00_0000_0000_0000};
        vecs[10] = '{11'h123, 0, 0, 4'd1,  64'hA5FF_FFFF_FFFF_FFFF, 15'h4000, 0, 1, 0, 0, 0, 1, 1, 0, 0, 11'h000, 0, 4'd0,  64'h0};

        reset = 1'b1;
        RX = 1'b1;
        repeat (2) @(posedge SP);
        #1;
        checkOutput("reset_pulses", 64'({EOF_Flag, Frame_Valid, Stuff_Error, Form_Error, CRC_Error}), 64'h0);
        checkOutput("reset_fields", 64'({ID, RTR, DLC}), 64'h0);
        checkOutput("reset_data", Data, 64'h0);
        checkOutput("reset_state", 64'(State), 64'(ST_WAIT_IDLE));
        reset = 1'b0;

        resetMonitor();
        repeat (10) sendBit(1'b1);
        checkOutput("idle_after_10_recessive", 64'(State), 64'(ST_WAIT_IDLE));
        sendBit(1'b1);
        checkOutput("idle_after_11_recessive", 64'(State), 64'(ST_IDLE));

        for (int k = 0; k < 11; k++) applyStimulus(vecs[k], k);

        // Frame B starts with a dominant bit in the second IFS slot after frame A.
        buildFrame(11'h123, 0, 0, 4'd1, 64'hA500_0000_0000_0000, 15'h0, 1, 1, 0);
        resetMonitor();
        foreach (txQ[i]) sendBit(txQ[i]);
        sendBit(1'b1);
        checkOutput("ifs_frame_a_valid", 64'(fvCnt), 64'd1);
        buildFrame(11'h456, 0, 0, 4'd2, 64'hBEEF_0000_0000_0000, 15'h0, 1, 1, 0);
        resetMonitor();
        foreach (txQ[i]) sendBit(txQ[i]);
        repeat (12) sendBit(1'b1);
        checkOutput("ifs_frame_b_valid", 64'(fvCnt), 64'd1);
        checkOutput("ifs_frame_b_fv_index", 64'(fvIdx), 64'(36 + 16 + nStuff));
        checkOutput("ifs_frame_b_id", 64'(ID), 64'h456);
        checkOutput("ifs_frame_b_dlc", 64'(DLC), 64'd2);
        checkOutput("ifs_frame_b_data", Data, 64'hBEEF_0000_0000_0000);
        checkOutput("ifs_frame_b_eof", 64'(eofCnt), 64'd7);

        // Reset in the middle of the data field.
        buildFrame(11'h123, 0, 0, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 15'h0, 1, 1, 0);
        resetMonitor();
        for (int i = 0; i < 28; i++) sendBit(txQ[i]);
        checkOutput("mid_data_state", 64'(State), 64'(ST_DATA));
        reset = 1'b1;
        RX = 1'b1;
        @(posedge SP);
        #1;
        checkOutput("mid_reset_pulses", 64'({EOF_Flag, Frame_Valid, Stuff_Error, Form_Error, CRC_Error}), 64'h0);
        checkOutput("mid_reset_fields", 64'({ID, RTR, DLC}), 64'h0);
        checkOutput("mid_reset_data", Data, 64'h0);
        checkOutput("mid_reset_state", 64'(State), 64'(ST_WAIT_IDLE));
        reset = 1'b0;
        resetMonitor();
        repeat (11) sendBit(1'b1);
        checkOutput("post_reset_errors", 64'(stuffCnt + formCnt + crcCnt), 64'd0);
        checkOutput("post_reset_idle", 64'(State), 64'(ST_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
